chrono_multi_timer: RTL and testbench
=====================================

// Module: chrono_multi_timer
// PURPOSE
//  Parametrised timekeeping core for the FPGA watch. It holds one 24 h time-of-day clock and NUM_TIMERS
//  independent countdown timers. All timers keep running in the background whatever mode is displayed.
//  It qualifies raw push-buttons by hold time and drives binary display fields to the digit/7-seg path.
// PARAMETERS
//  TICK_DIV      100_000_000  clk cycles per 1 s tick (>=2)
//  HOLD_CYC      15_000_000   cycles a button must be held continuously to register one press (>=1)
//  NUM_TIMERS    2            number of countdown channels (1..8)
//  TMR_MAX_MIN   99           max timer minutes (<=127)
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high; clears all state
//  btn_mode    in   1   raw button: cycle mode CLOCK->EDIT->TIMER->CLOCK
//  btn_shift   in   1   raw button: toggle edit field
//  btn_inc     in   1   raw button: increment selected field
//  btn_ss      in   1   raw button: start/stop selected timer
//  btn_sel     in   1   raw button: next timer channel (TIMER mode only)
//  mode_led    out  3   one-hot: 100 CLOCK, 010 EDIT, 001 TIMER
//  edit_field  out  1   1 = upper field (hours / timer min), 0 = lower field (minutes / timer sec)
//  sel_timer   out  3   selected timer channel index
//  disp_hours  out  5   displayed hours (0 in TIMER mode)
//  disp_min    out  7   displayed minutes
//  disp_sec    out  6   displayed seconds
//  timer_run   out  NUM_TIMERS  per-channel running flag
//  timer_done  out  NUM_TIMERS  per-channel sticky expiry flag
//  press_ack   out  1   high while any qualified press is still held (confirmation LED)
// BEHAVIOUR
//  Reset values:
//   mode CLOCK, mode_led=100, edit_field=1, sel_timer=0.
//   Clock, all timers, timer_run and timer_done all 0. Tick counter 0, hold counters 0, press_ack=0.
//  Tick:
//   The tick counter runs 0..TICK_DIV-1 and is never held in reset by mode.
//   tick is a one-cycle pulse while count==TICK_DIV-1; first tick is TICK_DIV cycles after reset release.
//  Press qualify:
//   Each button has its own hold counter, which saturates at HOLD_CYC.
//   The event pulses exactly once, on the cycle the counter reaches HOLD_CYC. No auto-repeat.
//   Releasing the button clears its counter. Press glitches shorter than HOLD_CYC are ignored.
//  Simultaneous events, same cycle: priority mode > shift > inc > ss > sel. Lower-priority events that cycle are dropped.
//  Clock (CLOCK/TIMER mode):
//   Each tick increments ss; 59->0 carries mm; 59->0 carries hh; 23->0.
//  Clock (EDIT mode):
//   Ticks are discarded and the clock is frozen.
//   inc: edit_field=1 increments hh (23->0); edit_field=0 increments mm (59->0).
//   shift toggles edit_field. Leaving EDIT forces ss=0.
//  Timers (TIMER mode, selected channel only):
//   ss toggles run. Start with value 00:00 is ignored (run stays 0).
//   inc while stopped: upper field min+1 (TMR_MAX_MIN->0), lower field sec+1 (59->0). inc while running is ignored.
//   shift toggles edit_field. sel: sel_timer+1, NUM_TIMERS-1 -> 0.
//   Any ss or inc event on a channel clears its done flag.
//  Timer countdown: each running channel decrements on every tick in any mode.
//   sec>0: sec-1. sec==0 and min>0: min-1, sec=59.
//   Transition to 00:00 on a tick: run=0 and done=1 on that same clock edge.
//  Tick + ss on the same channel and cycle: ss applies and that channel's decrement is suppressed.
//  Tick + mode change on the same cycle: both apply. Clock increment uses the pre-change mode.
//  Display: CLOCK/EDIT show the clock. TIMER shows hours=0 with the selected timer's min/sec.
//  Latency: all outputs are registered and reflect an event or tick one cycle after it.
//  Reset mid-countdown or mid-press aborts immediately. Nothing is remembered.
// TESTING  (TICK_DIV=4, HOLD_CYC=3, NUM_TIMERS=2)
//  Pulse btn_inc for 2 cycles -> no change; hold it 10 cycles -> exactly one increment.
//  Press btn_ss with no mode change -> mode_led stays 100.
//  Hold btn_ss and btn_mode together -> only the mode changes; the timer is unaffected.
//  Clock at 23:59:59, one tick -> 00:00:00.
//  Enter EDIT, inc hh x3, shift, inc mm x61 -> 03:01; on exit ss=00.
//  Stay in EDIT for 20 ticks -> the clock does not advance.
//  TIMER, ch0: shift (lower field), inc x2 -> 00:02; ss -> run=1.
//  After 2 ticks -> 00:00, run=0, done[0]=1 on the same edge.
//  Press ss on timer ch0 at 00:00 -> done cleared, run stays 0.
//  Timer ch1 set to 01:00 and started, then mode -> CLOCK.
//  After 60 ticks -> done[1]=1, and the clock advanced 60 s.
//  Assert reset during a running timer -> next cycle all outputs equal reset values.

Source files
------------

// File: rtl/chrono_multi_timer.sv
// Watch timekeeping core: one 24 h time-of-day clock plus NUM_TIMERS background countdown
// timers, driven by hold-qualified push-buttons and presenting binary display fields.
module chrono_multi_timer #(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned HOLD_CYC    = 15_000_000,
  parameter int unsigned NUM_TIMERS  = 2,
  parameter int unsigned TMR_MAX_MIN = 99
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_btn_mode,
  input  logic                  i_btn_shift,
  input  logic                  i_btn_inc,
  input  logic                  i_btn_ss,
  input  logic                  i_btn_sel,
  output logic [2:0]            o_mode_led,
  output logic                  o_edit_field,
  output logic [2:0]            o_sel_timer,
  output logic [4:0]            o_disp_hours,
  output logic [6:0]            o_disp_min,
  output logic [5:0]            o_disp_sec,
  output logic [NUM_TIMERS-1:0] o_timer_run,
  output logic [NUM_TIMERS-1:0] o_timer_done,
  output logic                  o_press_ack
);

  localparam int unsigned TickW  = $clog2(TICK_DIV);
  localparam int unsigned HoldW  = $clog2(HOLD_CYC + 1);
  localparam int unsigned NumBtn = 5;

  typedef enum logic [1:0] {StClock, StEdit, StTimer} mode_e;

  mode_e                 r_mode, w_mode_next;
  logic [TickW-1:0]      r_tick_cnt;
  logic                  w_tick;
  logic [HoldW-1:0]      r_hold      [NumBtn];
  logic [HoldW-1:0]      w_hold_next [NumBtn];
  logic [NumBtn-1:0]     w_btn, w_evt;
  logic                  w_ack, r_press_ack;
  logic                  w_ev_mode, w_ev_shift, w_ev_inc, w_ev_ss, w_ev_sel;
  logic                  r_edit_field;
  logic [2:0]            r_sel;
  logic [4:0]            r_hh;
  logic [5:0]            r_mm, r_ss;
  logic [6:0]            r_tmin [NUM_TIMERS];
  logic [5:0]            r_tsec [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] r_run, r_done, w_chan_sel;

  assign w_btn  = {i_btn_sel, i_btn_ss, i_btn_inc, i_btn_shift, i_btn_mode};
  assign w_tick = (r_tick_cnt == TickW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || w_tick) r_tick_cnt <= '0;
    else                 r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // Event fires on the cycle the counter steps onto HOLD_CYC; saturation blocks auto-repeat.
  always_comb begin
    w_evt = '0;
    w_ack = 1'b0;
    for (int i = 0; i < NumBtn; i++) begin
      w_hold_next[i] = '0;
      if (w_btn[i]) begin
        w_hold_next[i] = (r_hold[i] == HoldW'(HOLD_CYC)) ? r_hold[i] : r_hold[i] + 1'b1;
        w_evt[i]       = (r_hold[i] == HoldW'(HOLD_CYC - 1));
      end
      w_ack = w_ack | (w_hold_next[i] == HoldW'(HOLD_CYC));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumBtn; i++) begin
      r_hold[i] <= reset ? '0 : w_hold_next[i];
    end
  end

  assign w_ev_mode  = w_evt[0];
  assign w_ev_shift = w_evt[1] & ~w_evt[0];
  assign w_ev_inc   = w_evt[2] & ~|w_evt[1:0];
  assign w_ev_ss    = w_evt[3] & ~|w_evt[2:0];
  assign w_ev_sel   = w_evt[4] & ~|w_evt[3:0];

  always_ff @(posedge clk) begin
    if (reset) r_mode <= StClock;
    else       r_mode <= w_mode_next;
  end

  always_comb begin
    w_mode_next = r_mode;
    if (w_ev_mode) begin
      case (r_mode)
        StClock: w_mode_next = StEdit;
        StEdit:  w_mode_next = StTimer;
        default: w_mode_next = StClock;
      endcase
    end
  end

  always_comb begin
    o_mode_led = 3'b100;
    case (r_mode)
      StEdit:  o_mode_led = 3'b010;
      StTimer: o_mode_led = 3'b001;
      default: o_mode_led = 3'b100;
    endcase
  end

  // Time of day; the tick is judged against the mode held before any same-cycle mode change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hh <= '0;
      r_mm <= '0;
      r_ss <= '0;
    end else if (r_mode == StEdit) begin
      if (w_ev_inc && r_edit_field)  r_hh <= (r_hh == 5'd23) ? '0 : r_hh + 1'b1;
      if (w_ev_inc && !r_edit_field) r_mm <= (r_mm == 6'd59) ? '0 : r_mm + 1'b1;
      if (w_ev_mode)                 r_ss <= '0;
    end else if (w_tick) begin
      if (r_ss != 6'd59) begin
        r_ss <= r_ss + 1'b1;
      end else begin
        r_ss <= '0;
        if (r_mm != 6'd59) begin
          r_mm <= r_mm + 1'b1;
        end else begin
          r_mm <= '0;
          r_hh <= (r_hh == 5'd23) ? '0 : r_hh + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_edit_field <= 1'b1;
      r_sel        <= '0;
      r_press_ack  <= 1'b0;
    end else begin
      r_press_ack <= w_ack;
      if (w_ev_shift && r_mode != StClock) r_edit_field <= ~r_edit_field;
      if (w_ev_sel && r_mode == StTimer) begin
        r_sel <= (r_sel == 3'(NUM_TIMERS - 1)) ? '0 : r_sel + 1'b1;
      end
    end
  end

  always_comb begin
    w_chan_sel = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      w_chan_sel[i] = (r_mode == StTimer) && (r_sel == 3'(i));
    end
  end

  // A start/stop on a channel takes precedence over that channel's decrement in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run  <= '0;
      r_done <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        r_tmin[i] <= '0;
        r_tsec[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (w_chan_sel[i] && w_ev_ss) begin
          r_done[i] <= 1'b0;
          if (r_run[i])                                   r_run[i] <= 1'b0;
          else if (r_tmin[i] != '0 || r_tsec[i] != '0)    r_run[i] <= 1'b1;
        end else begin
          if (w_chan_sel[i] && w_ev_inc) begin
            r_done[i] <= 1'b0;
            if (!r_run[i] && r_edit_field) begin
              r_tmin[i] <= (r_tmin[i] == 7'(TMR_MAX_MIN)) ? '0 : r_tmin[i] + 1'b1;
            end
            if (!r_run[i] && !r_edit_field) begin
              r_tsec[i] <= (r_tsec[i] == 6'd59) ? '0 : r_tsec[i] + 1'b1;
            end
          end
          if (r_run[i] && w_tick) begin
            if (r_tsec[i] != '0) begin
              r_tsec[i] <= r_tsec[i] - 1'b1;
              if (r_tmin[i] == '0 && r_tsec[i] == 6'd1) begin
                r_run[i]  <= 1'b0;
                r_done[i] <= 1'b1;
              end
            end else if (r_tmin[i] != '0) begin
              r_tmin[i] <= r_tmin[i] - 1'b1;
              r_tsec[i] <= 6'd59;
            end
          end
        end
      end
    end
  end

  always_comb begin
    o_disp_hours = r_hh;
    o_disp_min   = {1'b0, r_mm};
    o_disp_sec   = r_ss;
    if (r_mode == StTimer) begin
      o_disp_hours = '0;
      o_disp_min   = '0;
      o_disp_sec   = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (r_sel == 3'(i)) begin
          o_disp_min = r_tmin[i];
          o_disp_sec = r_tsec[i];
        end
      end
    end
  end

  assign o_edit_field = r_edit_field;
  assign o_sel_timer  = r_sel;
  assign o_timer_run  = r_run;
  assign o_timer_done = r_done;
  assign o_press_ack  = r_press_ack;

endmodule

// File: tb/tb_chrono_multi_timer.sv
// Directed bench for chrono_multi_timer with TICK_DIV=4, HOLD_CYC=3, NUM_TIMERS=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_chrono_multi_timer;

  localparam logic [4:0] BMode  = 5'b00001;
  localparam logic [4:0] BShift = 5'b00010;
  localparam logic [4:0] BInc   = 5'b00100;
  localparam logic [4:0] BSs    = 5'b01000;
  localparam logic [4:0] BSel   = 5'b10000;

  logic       clk, reset;
  logic       btn_mode, btn_shift, btn_inc, btn_ss, btn_sel;
  logic [2:0] mode_led, sel_timer;
  logic       edit_field, press_ack;
  logic [4:0] disp_hours;
  logic [6:0] disp_min;
  logic [5:0] disp_sec;
  logic [1:0] timer_run, timer_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  chrono_multi_timer #(
    .TICK_DIV   (4),
    .HOLD_CYC   (3),
    .NUM_TIMERS (2),
    .TMR_MAX_MIN(99)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_btn_mode  (btn_mode),
    .i_btn_shift (btn_shift),
    .i_btn_inc   (btn_inc),
    .i_btn_ss    (btn_ss),
    .i_btn_sel   (btn_sel),
    .o_mode_led  (mode_led),
    .o_edit_field(edit_field),
    .o_sel_timer (sel_timer),
    .o_disp_hours(disp_hours),
    .o_disp_min  (disp_min),
    .o_disp_sec  (disp_sec),
    .o_timer_run (timer_run),
    .o_timer_done(timer_done),
    .o_press_ack (press_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge number since the last reset edge; ticks land on edges that are multiples of 4.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] m);
    {btn_sel, btn_ss, btn_inc, btn_shift, btn_mode} = m;
  endtask

  // Event lands on the 3rd edge after the call; returns one released edge later.
  task automatic press(input logic [4:0] m);
    drive(m);
    step(3);
    drive(5'b0);
    step(1);
  endtask

  task automatic do_reset();
    drive(5'b0);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (mode_led !== 3'b100 || edit_field !== 1'b1 || sel_timer !== 3'd0) begin
      failures++;
      $display("FAIL reset_ui got led=%b edit=%b sel=%0d exp led=100 edit=1 sel=0",
               mode_led, edit_field, sel_timer);
    end
    checks++;
    if ({disp_hours, disp_min, disp_sec} !== 18'd0 || timer_run !== 2'b00 ||
        timer_done !== 2'b00 || press_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got %0d:%0d:%0d run=%b done=%b ack=%b exp all zero",
               disp_hours, disp_min, disp_sec, timer_run, timer_done, press_ack);
    end
    step(3);
    checks++;
    if (disp_sec !== 6'd0) begin
      failures++;
      $display("FAIL tick_early got sec=%0d exp 0", disp_sec);
    end
    step(1);
    checks++;
    if (disp_sec !== 6'd1) begin
      failures++;
      $display("FAIL tick_first got sec=%0d exp 1", disp_sec);
    end
  endtask

  task automatic test_press_qualify();
    do_reset();
    btn_mode = 1'b1;
    step(2);
    checks++;
    if (mode_led !== 3'b100 || press_ack !== 1'b0) begin
      failures++;
      $display("FAIL hold_short got led=%b ack=%b exp led=100 ack=0", mode_led, press_ack);
    end
    step(1);
    checks++;
    if (mode_led !== 3'b010 || press_ack !== 1'b1) begin
      failures++;
      $display("FAIL hold_reached got led=%b ack=%b exp led=010 ack=1", mode_led, press_ack);
    end
    step(5);
    checks++;
    if (mode_led !== 3'b010 || press_ack !== 1'b1) begin
      failures++;
      $display("FAIL no_repeat got led=%b ack=%b exp led=010 ack=1", mode_led, press_ack);
    end
    btn_mode = 1'b0;
    step(1);
    checks++;
    if (press_ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_release got ack=%b exp 0", press_ack);
    end
    btn_inc = 1'b1;
    step(2);
    btn_inc = 1'b0;
    step(1);
    checks++;
    if (disp_hours !== 5'd0) begin
      failures++;
      $display("FAIL glitch_ignored got hh=%0d exp 0", disp_hours);
    end
    btn_inc = 1'b1;
    step(10);
    btn_inc = 1'b0;
    step(1);
    checks++;
    if (disp_hours !== 5'd1) begin
      failures++;
      $display("FAIL long_hold_once got hh=%0d exp 1", disp_hours);
    end
  endtask

  task automatic test_edit();
    do_reset();
    step(10);
    press(BMode);
    checks++;
    if (mode_led !== 3'b010 || disp_sec !== 6'd3) begin
      failures++;
      $display("FAIL edit_enter got led=%b sec=%0d exp led=010 sec=3", mode_led, disp_sec);
    end
    repeat (3) press(BInc);
    press(BShift);
    checks++;
    if (edit_field !== 1'b0 || disp_hours !== 5'd3) begin
      failures++;
      $display("FAIL edit_hours got field=%b hh=%0d exp field=0 hh=3", edit_field, disp_hours);
    end
    repeat (61) press(BInc);
    step(80);
    checks++;
    if (disp_hours !== 5'd3 || disp_min !== 7'd1 || disp_sec !== 6'd3) begin
      failures++;
      $display("FAIL edit_frozen got %0d:%0d:%0d exp 3:1:3", disp_hours, disp_min, disp_sec);
    end
    press(BMode);
    checks++;
    if (mode_led !== 3'b001 || disp_hours !== 5'd0) begin
      failures++;
      $display("FAIL timer_view got led=%b hh=%0d exp led=001 hh=0", mode_led, disp_hours);
    end
    press(BMode);
    checks++;
    if (mode_led !== 3'b100 || disp_hours !== 5'd3 || disp_min !== 7'd1 ||
        disp_sec !== 6'd1) begin
      failures++;
      $display("FAIL edit_exit got led=%b %0d:%0d:%0d exp led=100 3:1:1 at cyc %0d",
               mode_led, disp_hours, disp_min, disp_sec, cyc);
    end
  endtask

  task automatic test_rollover();
    int n;
    do_reset();
    press(BMode);
    repeat (23) press(BInc);
    press(BShift);
    repeat (59) press(BInc);
    press(BMode);
    press(BMode);
    n = 0;
    while (disp_sec !== 6'd59 && n < 400) begin
      step(1);
      n++;
    end
    checks++;
    if (cyc !== 572 || disp_hours !== 5'd23 || disp_min !== 7'd59) begin
      failures++;
      $display("FAIL pre_roll got cyc=%0d %0d:%0d:%0d exp cyc=572 23:59:59",
               cyc, disp_hours, disp_min, disp_sec);
    end
    step(3);
    checks++;
    if (disp_sec !== 6'd59) begin
      failures++;
      $display("FAIL roll_hold got sec=%0d exp 59", disp_sec);
    end
    step(1);
    checks++;
    if ({disp_hours, disp_min, disp_sec} !== 18'd0) begin
      failures++;
      $display("FAIL rollover got %0d:%0d:%0d exp 0:0:0", disp_hours, disp_min, disp_sec);
    end
  endtask

  task automatic test_timer_ch0();
    int n;
    do_reset();
    press(BSs);
    checks++;
    if (mode_led !== 3'b100 || timer_run !== 2'b00) begin
      failures++;
      $display("FAIL ss_in_clock got led=%b run=%b exp led=100 run=00", mode_led, timer_run);
    end
    do_reset();
    press(BMode);
    press(BMode);
    press(BShift);
    press(BInc);
    press(BInc);
    checks++;
    if (mode_led !== 3'b001 || edit_field !== 1'b0 || disp_min !== 7'd0 ||
        disp_sec !== 6'd2) begin
      failures++;
      $display("FAIL timer_set got led=%b field=%b %0d:%0d exp led=001 field=0 0:2",
               mode_led, edit_field, disp_min, disp_sec);
    end
    press(BSs | BMode);
    checks++;
    if (mode_led !== 3'b100 || timer_run !== 2'b00) begin
      failures++;
      $display("FAIL priority got led=%b run=%b exp led=100 run=00", mode_led, timer_run);
    end
    press(BMode);
    press(BMode);
    checks++;
    if (disp_sec !== 6'd2 || timer_run !== 2'b00) begin
      failures++;
      $display("FAIL timer_kept got sec=%0d run=%b exp sec=2 run=00", disp_sec, timer_run);
    end
    press(BSs);
    checks++;
    if (timer_run !== 2'b01 || disp_sec !== 6'd1) begin
      failures++;
      $display("FAIL timer_start got run=%b sec=%0d exp run=01 sec=1", timer_run, disp_sec);
    end
    n = 0;
    while (timer_run[0] !== 1'b0 && n < 20) begin
      step(1);
      n++;
    end
    checks++;
    if (cyc !== 40 || disp_sec !== 6'd0 || disp_min !== 7'd0 || timer_done !== 2'b01) begin
      failures++;
      $display("FAIL timer_expire got cyc=%0d %0d:%0d done=%b exp cyc=40 0:0 done=01",
               cyc, disp_min, disp_sec, timer_done);
    end
    press(BSs);
    checks++;
    if (timer_done !== 2'b00 || timer_run !== 2'b00) begin
      failures++;
      $display("FAIL zero_start got run=%b done=%b exp run=00 done=00", timer_run, timer_done);
    end
    press(BSel);
    checks++;
    if (sel_timer !== 3'd1) begin
      failures++;
      $display("FAIL sel_next got sel=%0d exp 1", sel_timer);
    end
    press(BSel);
    checks++;
    if (sel_timer !== 3'd0) begin
      failures++;
      $display("FAIL sel_wrap got sel=%0d exp 0", sel_timer);
    end
  endtask

  task automatic test_timer_ch1_background();
    int n;
    do_reset();
    press(BMode);
    press(BMode);
    press(BSel);
    press(BInc);
    checks++;
    if (sel_timer !== 3'd1 || disp_min !== 7'd1 || disp_sec !== 6'd0) begin
      failures++;
      $display("FAIL ch1_set got sel=%0d %0d:%0d exp sel=1 1:0", sel_timer, disp_min, disp_sec);
    end
    press(BSs);
    checks++;
    if (timer_run !== 2'b10 || disp_min !== 7'd0 || disp_sec !== 6'd59) begin
      failures++;
      $display("FAIL ch1_borrow got run=%b %0d:%0d exp run=10 0:59",
               timer_run, disp_min, disp_sec);
    end
    press(BMode);
    n = 0;
    while (timer_done[1] !== 1'b1 && n < 400) begin
      step(1);
      n++;
    end
    checks++;
    if (cyc !== 256 || timer_run !== 2'b00 || timer_done !== 2'b10) begin
      failures++;
      $display("FAIL ch1_expire got cyc=%0d run=%b done=%b exp cyc=256 run=00 done=10",
               cyc, timer_run, timer_done);
    end
    checks++;
    if (mode_led !== 3'b100 || disp_hours !== 5'd0 || disp_min !== 7'd1 ||
        disp_sec !== 6'd3) begin
      failures++;
      $display("FAIL clock_bg got led=%b %0d:%0d:%0d exp led=100 0:1:3",
               mode_led, disp_hours, disp_min, disp_sec);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(BMode);
    press(BMode);
    press(BInc);
    press(BSs);
    checks++;
    if (timer_run !== 2'b01) begin
      failures++;
      $display("FAIL mid_running got run=%b exp 01", timer_run);
    end
    btn_inc = 1'b1;
    step(2);
    reset = 1'b1;
    step(1);
    checks++;
    if (mode_led !== 3'b100 || edit_field !== 1'b1 || sel_timer !== 3'd0 ||
        {disp_hours, disp_min, disp_sec} !== 18'd0 || timer_run !== 2'b00 ||
        timer_done !== 2'b00 || press_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got led=%b edit=%b sel=%0d %0d:%0d:%0d run=%b done=%b ack=%b exp reset values",
               mode_led, edit_field, sel_timer, disp_hours, disp_min, disp_sec,
               timer_run, timer_done, press_ack);
    end
    reset   = 1'b0;
    btn_inc = 1'b0;
    step(1);
  endtask

  initial begin
    drive(5'b0);
    reset = 1'b1;
    test_reset();
    test_press_qualify();
    test_edit();
    test_rollover();
    test_timer_ch0();
    test_timer_ch1_background();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
